mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 19 +
 rtl/mul_sequencer_adder.sv | 18 +
 rtl/mul_sequencer.sv | 112 +++++++++++
 tb/tb_mul_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the shift-add multiplier: FSM state encodings,
// the default operand width and the step-counter sizing helper.
package mul_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The step counter must be able to hold the value WIDTH itself,
  // so it needs one bit more than $clog2(WIDTH).
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_sequencer_adder.sv
// Plain ripple-style WIDTH-bit adder with carry in/out. Used by the
// multiplier for the per-step partial-product addition.
module mul_sequencer_adder
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // Extend both operands by one bit so the carry lands in the MSB.
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/mul_sequencer.sv
// Sequential unsigned multiplier: one shift-add step per clock, fixed
// latency of WIDTH edges from acceptance to resp_valid.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; req_ready high unless flush
//   RUN   | one shift-add step per edge, WIDTH steps in total
//   DONE  | product held on result with resp_valid high until taken
//
// flush returns to IDLE from any state and beats both acceptance and the
// response handshake.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               step_last;
  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;
  logic [WIDTH:0]     upper;

  assign req_ready  = (state == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign step_last  = (cnt == LAST_STEP);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign result     = acc;

  mul_sequencer_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a         (acc[2*WIDTH-1:WIDTH]),
    .b         (mcand),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // Upper half for this step: add the multiplicand only when the current
  // multiplier LSB is set; the carry becomes the extra top bit.
  assign upper = mplier[0] ? {add_carry, add_sum} : {1'b0, acc[2*WIDTH-1:WIDTH]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)     state_next = RUN;
        RUN:     if (step_last)  state_next = DONE;
        DONE:    if (resp_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: latch operands at acceptance, then shift-add while in RUN.
  // A flushed RUN step still updates acc, which is harmless because the
  // next acceptance clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= {upper, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer at WIDTH=4 and WIDTH=32. Drivers push
// hand-computed products plus the expected resp_valid edge; per-instance
// monitors pop and compare whenever a response is presented.
module tb_mul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       req_valid4, req_ready4, flush4, resp_valid4, resp_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] result4;

  logic        req_valid32, req_ready32, flush32, resp_valid32, resp_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] result32;

  mul_sequencer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .a(a4), .b(b4), .flush(flush4), .resp_valid(resp_valid4),
    .resp_ready(resp_ready4), .result(result4), .busy(busy4)
  );

  mul_sequencer #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid32), .req_ready(req_ready32),
    .a(a32), .b(b32), .flush(flush32), .resp_valid(resp_valid32),
    .resp_ready(resp_ready32), .result(result32), .busy(busy32)
  );

  typedef struct {
    logic [63:0] res;
    int          rise;
  } exp_t;

  exp_t q4[$];
  exp_t q32[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-bit instance.
  logic rv4_d = 1'b0;
  always @(negedge clk) begin
    if (resp_valid4 && !rv4_d) begin
      check("resp4_expected", 64'(q4.size() != 0), 64'(1));
      if (q4.size() != 0) check("latency4", 64'(cyc), 64'(q4[0].rise));
    end
    if (resp_valid4 && q4.size() != 0) begin
      check("result4", 64'(result4), q4[0].res);
      if (resp_ready4) void'(q4.pop_front());
    end
    rv4_d <= resp_valid4;
  end

  // Monitor for the 32-bit instance.
  logic rv32_d = 1'b0;
  always @(negedge clk) begin
    if (resp_valid32 && !rv32_d) begin
      check("resp32_expected", 64'(q32.size() != 0), 64'(1));
      if (q32.size() != 0) check("latency32", 64'(cyc), 64'(q32[0].rise));
    end
    if (resp_valid32 && q32.size() != 0) begin
      check("result32", result32, q32[0].res);
      if (resp_ready32) void'(q32.pop_front());
    end
    rv32_d <= resp_valid32;
  end

  task automatic issue4(input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] expv, input bit push);
    int n = 0;
    @(negedge clk);
    while (!req_ready4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready4_wait", 64'(req_ready4), 64'(1));
    a4 = av;
    b4 = bv;
    req_valid4 = 1'b1;
    @(posedge clk);
    #1;
    if (push) q4.push_back('{res: 64'(expv), rise: cyc + 4});
    req_valid4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
  endtask

  task automatic issue32(input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] expv);
    int n = 0;
    @(negedge clk);
    while (!req_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready32_wait", 64'(req_ready32), 64'(1));
    a32 = av;
    b32 = bv;
    req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    q32.push_back('{res: expv, rise: cyc + 32});
    req_valid32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (busy4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle4_timeout", 64'(busy4), 64'(0));
  endtask

  task automatic wait_idle32();
    int n = 0;
    while (busy32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle32_timeout", 64'(busy32), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid4 = 1'b0; flush4 = 1'b0; resp_ready4 = 1'b1; a4 = '0; b4 = '0;
    req_valid32 = 1'b0; flush32 = 1'b0; resp_ready32 = 1'b1; a32 = '0; b32 = '0;

    #2;
    check("rst_req_ready", 64'(req_ready4), 64'(1));
    check("rst_resp_valid", 64'(resp_valid4), 64'(0));
    check("rst_busy", 64'(busy4), 64'(0));
    check("rst_result", 64'(result4), 64'(0));
    check("rst_result32", result32, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 15*15 with req_ready low through edges 1..4.
    issue4(4'hF, 4'hF, 8'hE1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check("req_ready4_busy", 64'(req_ready4), 64'(0));
    end
    wait_idle4();

    issue4(4'h3, 4'h5, 8'h0F, 1'b1); wait_idle4();
    issue4(4'h0, 4'hF, 8'h00, 1'b1); wait_idle4();
    issue4(4'hF, 4'h0, 8'h00, 1'b1); wait_idle4();
    issue4(4'hA, 4'hB, 8'h6E, 1'b1); wait_idle4();
    issue4(4'h1, 4'h1, 8'h01, 1'b1); wait_idle4();
    issue4(4'h8, 4'h8, 8'h40, 1'b1); wait_idle4();
    issue4(4'hF, 4'h1, 8'h0F, 1'b1); wait_idle4();

    // Hold in DONE with resp_ready low while operands toggle.
    resp_ready4 = 1'b0;
    issue4(4'hF, 4'hF, 8'hE1, 1'b1);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      check("hold_resp_valid", 64'(resp_valid4), 64'(1));
      check("hold_result", 64'(result4), 64'(8'hE1));
      check("hold_req_ready", 64'(req_ready4), 64'(0));
    end
    @(negedge clk);
    resp_ready4 = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_req_ready", 64'(req_ready4), 64'(1));
    check("post_hs_resp_valid", 64'(resp_valid4), 64'(0));

    // Flush at RUN step 2 discards the product.
    issue4(4'h7, 4'h7, 8'h31, 1'b0);
    @(posedge clk);
    #1;
    flush4 = 1'b1;
    check("flush_req_ready_comb", 64'(req_ready4), 64'(0));
    @(posedge clk);
    #1;
    check("flush_busy", 64'(busy4), 64'(0));
    check("flush_resp_valid", 64'(resp_valid4), 64'(0));
    flush4 = 1'b0;
    #1;
    check("flush_req_ready", 64'(req_ready4), 64'(1));
    repeat (6) @(negedge clk);
    check("flush_no_resp", 64'(resp_valid4), 64'(0));
    issue4(4'h3, 4'h5, 8'h0F, 1'b1); wait_idle4();

    // Asynchronous reset between edges in the middle of RUN.
    issue4(4'hF, 4'hF, 8'hE1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy4), 64'(0));
    check("async_rst_req_ready", 64'(req_ready4), 64'(1));
    check("async_rst_resp_valid", 64'(resp_valid4), 64'(0));
    check("async_rst_result", 64'(result4), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // flush and req_valid together in IDLE must not accept.
    @(negedge clk);
    flush4 = 1'b1;
    req_valid4 = 1'b1;
    a4 = 4'h9;
    b4 = 4'h9;
    @(posedge clk);
    #1;
    check("flush_blocks_accept", 64'(busy4), 64'(0));
    flush4 = 1'b0;
    req_valid4 = 1'b0;
    issue4(4'h2, 4'h3, 8'h06, 1'b1); wait_idle4();

    // 32-bit vectors, fixed 32-edge latency.
    issue32(32'hFFFF_FFFF, 32'h2, 64'h1_FFFF_FFFE); wait_idle32();
    issue32(32'h0, 32'd123, 64'h0); wait_idle32();
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001); wait_idle32();

    repeat (3) @(negedge clk);
    check("q4_drained", 64'(q4.size()), 64'(0));
    check("q32_drained", 64'(q32.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
